// File: rtl/div_iter.sv
// Iterative DIV/IDIV unit: restoring division, one quotient bit per cycle, 8- or 16-bit results.
// Define IDIV_MINNEG_EN to accept the most-negative signed quotient (-32768 / -128).
module div_iter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] x_i,
  input  logic [15:0] y_i,
  input  logic        signed_op_i,
  input  logic        word_op_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] out_o,
  output logic        exc_o
);

`ifdef IDIV_MINNEG_EN
  localparam logic [15:0] NegLimW = 16'd32768;
  localparam logic [15:0] NegLimB = 16'd128;
`else
  localparam logic [15:0] NegLimW = 16'd32767;
  localparam logic [15:0] NegLimB = 16'd127;
`endif

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] low_q, low_d;
  logic [15:0] dvs_q, dvs_d;
  logic        word_q, word_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        exc_pend_q, exc_pend_d;
  logic [31:0] out_q, out_d;
  logic        exc_q, exc_d;

  logic        x_neg, y_neg, pre_ovf;
  logic [31:0] dvd_w;
  logic [15:0] dvd_b, dvs_w;
  logic [7:0]  dvs_b;
  logic [16:0] trial;
  logic [15:0] diff;
  logic        fits;
  logic [15:0] quo_m, rem_m, quo_s, rem_s;
  logic        ovf;

  // Operand magnitudes at latch time; byte ops use the low halves of x and y.
  always_comb begin
    x_neg   = signed_op_i & (word_op_i ? x_i[31] : x_i[15]);
    y_neg   = signed_op_i & (word_op_i ? y_i[15] : y_i[7]);
    dvd_w   = x_neg ? 32'd0 - x_i : x_i;
    dvd_b   = x_neg ? 16'd0 - x_i[15:0] : x_i[15:0];
    dvs_w   = y_neg ? 16'd0 - y_i : y_i;
    dvs_b   = y_neg ? 8'd0 - y_i[7:0] : y_i[7:0];
    pre_ovf = word_op_i ? (dvd_w[31:16] >= dvs_w) : (dvd_b[15:8] >= dvs_b);
  end

  // Remainder stays below the divisor, so the low 16 bits of the difference are exact.
  always_comb begin
    trial = {rem_q, low_q[15]};
    diff  = trial[15:0] - dvs_q;
    fits  = trial >= {1'b0, dvs_q};
  end

  always_comb begin
    quo_m = word_q ? low_q : {8'd0, low_q[7:0]};
    rem_m = word_q ? rem_q : {8'd0, rem_q[7:0]};
    quo_s = qneg_q ? 16'd0 - quo_m : quo_m;
    rem_s = rneg_q ? 16'd0 - rem_m : rem_m;
    ovf   = sgn_q & (quo_m > (word_q ? (qneg_q ? NegLimW : 16'd32767)
                                     : (qneg_q ? NegLimB : 16'd127)));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    low_d      = low_q;
    dvs_d      = dvs_q;
    word_d     = word_q;
    sgn_d      = sgn_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    exc_pend_d = exc_pend_q;
    out_d      = out_q;
    exc_d      = exc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start_i) begin
          word_d     = word_op_i;
          sgn_d      = signed_op_i;
          qneg_d     = x_neg ^ y_neg;
          rneg_d     = x_neg;
          exc_pend_d = pre_ovf;
          cnt_d      = word_op_i ? 4'd15 : 4'd7;
          // Byte dividend low half is left-aligned so both widths shift out of bit 15.
          rem_d      = word_op_i ? dvd_w[31:16] : {8'd0, dvd_b[15:8]};
          low_d      = word_op_i ? dvd_w[15:0] : {dvd_b[7:0], 8'd0};
          dvs_d      = word_op_i ? dvs_w : {8'd0, dvs_b};
          state_d    = pre_ovf ? StFix : StCalc;
        end
      end
      StCalc: begin
        low_d = {low_q[14:0], fits};
        rem_d = fits ? diff : trial[15:0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
        if (exc_pend_q || ovf) begin
          exc_d = 1'b1;
        end else begin
          exc_d = 1'b0;
          out_d = word_q ? {rem_s, quo_s} : {16'd0, rem_s[7:0], quo_s[7:0]};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rem_q      <= 16'd0;
      low_q      <= 16'd0;
      dvs_q      <= 16'd0;
      word_q     <= 1'b0;
      sgn_q      <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      exc_pend_q <= 1'b0;
      out_q      <= 32'd0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      low_q      <= low_d;
      dvs_q      <= dvs_d;
      word_q     <= word_d;
      sgn_q      <= sgn_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      exc_pend_q <= exc_pend_d;
      out_q      <= out_d;
      exc_q      <= exc_d;
    end
  end

  assign busy_o = (state_q == StCalc) || (state_q == StFix);
  assign done_o = (state_q == StDone);
  assign out_o  = out_q;
  assign exc_o  = exc_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scoreboard of expected results against an integer model.
// Latency m means done is seen high at the m-th falling edge after the start edge E0.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = 32'd0;
  logic [15:0] y = 16'd0;
  logic        s = 1'b0;
  logic        w = 1'b0;
  logic        busy, done, exc;
  logic [31:0] out;

  typedef struct {
    logic [31:0] out;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_out = 32'd0;

  div_iter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .x_i        (x),
    .y_i        (y),
    .signed_op_i(s),
    .word_op_i  (w),
    .busy_o     (busy),
    .done_o     (done),
    .out_o      (out),
    .exc_o      (exc)
  );

  always #5 clk = ~clk;

  // Directed vectors: x, y, signed, word, expected out, exc, latency.
  logic [31:0] tx[6]   = '{32'h00010005, 32'h00001234, 32'h00020000, 32'h00000064,
                           32'hFFFFFFF9, 32'h0000FF80};
  logic [15:0] ty[6]   = '{16'h0010, 16'h0000, 16'h0001, 16'h0007, 16'h0002, 16'h0001};
  logic        ts[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        tw[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef IDIV_MINNEG_EN
  logic [31:0] tout[6] = '{32'h00051000, 32'h00051000, 32'h00051000, 32'h0000020E,
                           32'hFFFFFFFD, 32'h00000080};
  logic        texc[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic [31:0] tout[6] = '{32'h00051000, 32'h00051000, 32'h00051000, 32'h0000020E,
                           32'hFFFFFFFD, 32'hFFFFFFFD};
  logic        texc[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
  int          tlat[6] = '{18, 2, 2, 10, 18, 10};

  function automatic exp_t model(input logic [31:0] mx, input logic [15:0] my, input bit ms,
                                 input bit mw, input logic [31:0] prev);
    exp_t   e;
    longint dvd, dvs, adv, ads, q, r, lim, lo, hi;
    int     n;
    n   = mw ? 16 : 8;
    lim = longint'(1) << n;
    if (mw) begin
      dvd = ms ? longint'($signed(mx)) : longint'(mx);
      dvs = ms ? longint'($signed(my)) : longint'(my);
    end else begin
      dvd = ms ? longint'($signed(mx[15:0])) : longint'(mx[15:0]);
      dvs = ms ? longint'($signed(my[7:0])) : longint'(my[7:0]);
    end
    e.out = prev;
    e.exc = 1'b1;
    e.lat = 2;
    if (dvs == 0) return e;
    adv = (dvd < 0) ? -dvd : dvd;
    ads = (dvs < 0) ? -dvs : dvs;
    if (adv / ads >= lim) return e;
    e.lat = n + 2;
    q = dvd / dvs;
    r = dvd % dvs;
    hi = lim / 2 - 1;
`ifdef IDIV_MINNEG_EN
    lo = -(lim / 2);
`else
    lo = -(lim / 2) + 1;
`endif
    if (ms && (q < lo || q > hi)) return e;
    e.exc = 1'b0;
    e.out = mw ? {r[15:0], q[15:0]} : {16'd0, r[7:0], q[7:0]};
    return e;
  endfunction

  task automatic push_model(input logic [31:0] mx, input logic [15:0] my, input bit ms,
                            input bit mw);
    exp_t e;
    e = model(mx, my, ms, mw, model_out);
    model_out = e.out;
    sb.push_back(e);
  endtask

  // Drive one request sampled at the next rising edge (E0), then scramble the inputs.
  task automatic issue(input logic [31:0] ix, input logic [15:0] iy, input bit is, input bit iw);
    @(negedge clk);
    x = ix; y = iy; s = is; w = iw; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = $urandom; y = 16'($urandom); s = ~is; w = ~iw;
  endtask

  // Returns the falling-edge index at which done is first seen, or -1 on timeout.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = -1;
    for (int m = 1; m <= 40; m++) begin
      @(negedge clk);
      start = (m == pulse_at);
      if (start) begin
        x = 32'h00000001; y = 16'h0001; s = 1'b0; w = 1'b0;
      end
      if (done === 1'b1) begin
        lat = m;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    if (exc !== 1'b0) begin errors++; $display("FAIL reset exc: got %b want 0", exc); end
    if (out !== 32'd0) begin errors++; $display("FAIL reset out: got %h want 0", out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    exp_t e;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      e.out = tout[i]; e.exc = texc[i]; e.lat = tlat[i];
      model_out = tout[i];
      sb.push_back(e);
      issue(tx[i], ty[i], ts[i], tw[i]);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d busy: got %b want 1", i, busy); end
      wait_done(0, lat);
      e = sb.pop_front();
      checks += 3;
      if (lat != e.lat) begin errors++; $display("FAIL vec%0d lat: got %0d want %0d", i, lat, e.lat); end
      if (out !== e.out) begin errors++; $display("FAIL vec%0d out: got %h want %h", i, out, e.out); end
      if (exc !== e.exc) begin errors++; $display("FAIL vec%0d exc: got %b want %b", i, exc, e.exc); end
      @(negedge clk);
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL vec%0d pulse: done=%b want 0", i, done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d idle: busy=%b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic [31:0] rx;
    logic [15:0] ry;
    bit          rs, rw;
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 1) == 1) rx = rx >> $urandom_range(8, 31);
      ry = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ry = ry >> $urandom_range(0, 15);
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      push_model(rx, ry, rs, rw);
      issue(rx, ry, rs, rw);
      wait_done(0, lat);
      e = sb.pop_front();
      checks += 3;
      if (lat != e.lat) begin errors++; $display("FAIL rnd%0d lat: got %0d want %0d", i, lat, e.lat); end
      if (out !== e.out) begin errors++; $display("FAIL rnd%0d out: got %h want %h", i, out, e.out); end
      if (exc !== e.exc) begin errors++; $display("FAIL rnd%0d exc: got %b want %b", i, exc, e.exc); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   lat;
    push_model(32'h12345678, 16'h5678, 1'b0, 1'b1);
    issue(32'h12345678, 16'h5678, 1'b0, 1'b1);
    wait_done(3, lat);
    e = sb.pop_front();
    checks += 3;
    if (lat != e.lat) begin errors++; $display("FAIL ignore lat: got %0d want %0d", lat, e.lat); end
    if (out !== e.out) begin errors++; $display("FAIL ignore out: got %h want %h", out, e.out); end
    if (exc !== e.exc) begin errors++; $display("FAIL ignore exc: got %b want %b", exc, e.exc); end
  endtask

  task automatic test_reset_midcalc();
    exp_t e;
    int   lat;
    issue(32'h00010005, 16'h0010, 1'b0, 1'b1);
    for (int m = 1; m <= 4; m++) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst done: got %b want 0", done); end
    if (exc !== 1'b0) begin errors++; $display("FAIL midrst exc: got %b want 0", exc); end
    if (out !== 32'd0) begin errors++; $display("FAIL midrst out: got %h want 0", out); end
    @(negedge clk);
    rst_n = 1'b1;
    model_out = 32'd0;
    wait_done(0, lat);
    checks++;
    if (lat != -1) begin errors++; $display("FAIL midrst stray done: got %0d want -1", lat); end
    push_model(32'h0000FF9C, 16'h0007, 1'b1, 1'b0);
    issue(32'h0000FF9C, 16'h0007, 1'b1, 1'b0);
    wait_done(0, lat);
    e = sb.pop_front();
    checks += 3;
    if (lat != e.lat) begin errors++; $display("FAIL postrst lat: got %0d want %0d", lat, e.lat); end
    if (out !== e.out) begin errors++; $display("FAIL postrst out: got %h want %h", out, e.out); end
    if (exc !== e.exc) begin errors++; $display("FAIL postrst exc: got %b want %b", exc, e.exc); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    push_model(32'h7FFF0001, 16'h8001, 1'b0, 1'b1);
    issue(32'h7FFF0001, 16'h8001, 1'b0, 1'b1);
    wait_done(0, lat);
    // Second request is driven while the first is still in DONE.
    x = 32'h0000FF38; y = 16'h00F9; s = 1'b1; w = 1'b0; start = 1'b1;
    e = sb.pop_front();
    checks += 3;
    if (lat != e.lat) begin errors++; $display("FAIL b2b first lat: got %0d want %0d", lat, e.lat); end
    if (out !== e.out) begin errors++; $display("FAIL b2b first out: got %h want %h", out, e.out); end
    if (exc !== e.exc) begin errors++; $display("FAIL b2b first exc: got %b want %b", exc, e.exc); end
    push_model(32'h0000FF38, 16'h00F9, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    x = $urandom; y = 16'($urandom);
    wait_done(0, lat);
    e = sb.pop_front();
    checks += 3;
    if (lat != e.lat) begin errors++; $display("FAIL b2b second lat: got %0d want %0d", lat, e.lat); end
    if (out !== e.out) begin errors++; $display("FAIL b2b second out: got %h want %h", out, e.out); end
    if (exc !== e.exc) begin errors++; $display("FAIL b2b second exc: got %b want %b", exc, e.exc); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_busy_ignore();
    test_reset_midcalc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
